// File: rtl/alu_mw_seq_if.sv
// Bundle of the operand stream, ALU drive/return bus and result stream of alu_mw_seq.
// slave is the sequencer's view; master is the surrounding CPU/ALU/consumer side.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface alu_mw_seq_if #(
   parameter int DATA_WIDTH = `DATA_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH-1:0] in_b;
   logic                  in_last;
   logic                  op_sub;
   logic [DATA_WIDTH-1:0] alu_A;
   logic [DATA_WIDTH-1:0] alu_B;
   logic [4:0]            alu_opcode;
   logic [DATA_WIDTH-1:0] alu_C;
   logic [3:0]            alu_status;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic [3:0]            flags;
   logic                  busy;

   modport slave (
      input  in_valid, in_a, in_b, in_last, op_sub, alu_C, alu_status, out_ready,
      output in_ready, alu_A, alu_B, alu_opcode, out_valid, out_data, out_last, flags, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_last, op_sub, alu_C, alu_status, out_ready,
      input  in_ready, alu_A, alu_B, alu_opcode, out_valid, out_data, out_last, flags, busy
   );
endinterface

// File: rtl/alu_mw_seq.sv
// Multi-word add/subtract sequencer: feeds word pairs LSW-first to the combinational
// ALU, chaining carry/borrow via ADC/SBB, and accumulates packet-level status flags.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module alu_mw_seq #(
   parameter int         DATA_WIDTH = `DATA_WIDTH,
   parameter logic [4:0] OP_ADD     = 5'h02,
   parameter logic [4:0] OP_ADC     = 5'h03,
   parameter logic [4:0] OP_SBB     = 5'h04,
   parameter logic [4:0] OP_SUB     = 5'h05,
   parameter logic [4:0] OP_LD      = 5'h00
) (
   input logic         clk,
   input logic         reset_n,
   alu_mw_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

   state_t state;
   logic   first;
   logic   carry_r;
   logic   sub_r;
   logic   last_r;
   logic   zacc;
   logic   pacc;
   logic   zacc_nxt;
   logic   pacc_nxt;

   assign bus.in_ready = (state == IDLE);

   always_comb begin
      zacc_nxt = zacc & bus.alu_status[2];
      pacc_nxt = pacc ^ bus.alu_status[1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         bus.alu_A      <= '0;
         bus.alu_B      <= '0;
         bus.alu_opcode <= OP_LD;
         bus.out_valid  <= 1'b0;
         bus.out_data   <= '0;
         bus.out_last   <= 1'b0;
         bus.flags      <= '0;
         bus.busy       <= 1'b0;
         first          <= 1'b1;
         carry_r        <= 1'b0;
         sub_r          <= 1'b0;
         last_r         <= 1'b0;
         zacc           <= 1'b1;
         pacc           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  bus.alu_A <= bus.in_a;
                  bus.alu_B <= bus.in_b;
                  last_r    <= bus.in_last;
                  // op_sub is only honoured on a packet's first word
                  if (first) begin
                     sub_r          <= bus.op_sub;
                     bus.alu_opcode <= bus.op_sub ? OP_SUB : OP_ADD;
                  end else if (sub_r) begin
                     bus.alu_opcode <= carry_r ? OP_SBB : OP_SUB;
                  end else begin
                     bus.alu_opcode <= carry_r ? OP_ADC : OP_ADD;
                  end
                  bus.busy <= 1'b1;
                  first    <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               bus.out_data  <= bus.alu_C;
               bus.out_last  <= last_r;
               bus.out_valid <= 1'b1;
               carry_r       <= bus.alu_status[0];
               zacc          <= zacc_nxt;
               pacc          <= pacc_nxt;
               if (last_r)
                  bus.flags <= {bus.alu_status[3], zacc_nxt, pacc_nxt, bus.alu_status[0]};
               state <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid  <= 1'b0;
                  bus.alu_opcode <= OP_LD;
                  if (bus.out_last) begin
                     first    <= 1'b1;
                     zacc     <= 1'b1;
                     pacc     <= 1'b0;
                     carry_r  <= 1'b0;
                     bus.busy <= 1'b0;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mw_seq.sv
// Bench for alu_mw_seq: directed and random packets against a big-integer reference,
// with a behavioural combinational ALU closing the loop.
module tb_alu_mw_seq;

   localparam int W = 8;
   localparam logic [4:0] OP_ADD = 5'h02, OP_ADC = 5'h03, OP_SBB = 5'h04,
                          OP_SUB = 5'h05, OP_LD = 5'h00;

   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   failures = 0;

   alu_mw_seq_if #(.DATA_WIDTH(W)) bus ();

   alu_mw_seq #(.DATA_WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Combinational ALU: carry is bit W of the extended result (borrow for SUB/SBB)
   logic [W:0] ext;
   always_comb begin
      ext = '0;
      case (bus.alu_opcode)
         OP_ADD:  ext = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
         OP_ADC:  ext = {1'b0, bus.alu_A} + {1'b0, bus.alu_B} + 1'b1;
         OP_SBB:  ext = {1'b0, bus.alu_A} - {1'b0, bus.alu_B} - 1'b1;
         OP_SUB:  ext = {1'b0, bus.alu_A} - {1'b0, bus.alu_B};
         default: ext = {1'b0, bus.alu_A};
      endcase
      bus.alu_C      = ext[W-1:0];
      bus.alu_status = {ext[W-1], (ext[W-1:0] == '0), ^ext[W-1:0], ext[W]};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sends the first nsend words of an n-word packet; the reference works on whole integers
   task automatic run_packet(input int n, input logic [63:0] a_in, input logic [63:0] b_in,
                             input logic sub, input int stall, input int nsend);
      logic [63:0] full, low, a, b, r, word_a, word_b, exp_word;
      logic [3:0]  exp_flags;
      logic [4:0]  exp_op;
      logic        cin, fin_carry;
      int          cnt;
      full = (64'd1 << (n * W)) - 64'd1;
      a = a_in & full;
      b = b_in & full;
      r = sub ? (a - b) : (a + b);
      fin_carry = sub ? (a < b) : ((((a + b) >> (n * W)) & 64'd1) != 0);
      exp_flags = {r[n*W-1], ((r & full) == 64'd0), ^(r & full), fin_carry};
      for (int i = 0; i < nsend; i++) begin
         low = (64'd1 << (i * W)) - 64'd1;
         if (sub) cin = ((a & low) < (b & low));
         else     cin = ((((a & low) + (b & low)) >> (i * W)) & 64'd1) != 0;
         if (sub) exp_op = cin ? OP_SBB : OP_SUB;
         else     exp_op = cin ? OP_ADC : OP_ADD;
         word_a   = (a >> (i * W)) & 64'hFF;
         word_b   = (b >> (i * W)) & 64'hFF;
         exp_word = (r >> (i * W)) & 64'hFF;

         @(negedge clk);
         bus.in_a     = word_a[W-1:0];
         bus.in_b     = word_b[W-1:0];
         bus.in_last  = (i == n - 1);
         bus.op_sub   = (i == 0) ? sub : 1'($urandom_range(1));
         bus.in_valid = 1'b1;
         cnt = 0;
         while (!bus.in_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
         end
         chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk("opcode", 64'(bus.alu_opcode), 64'(exp_op));
         chk("alu_A", 64'(bus.alu_A), word_a);
         chk("alu_B", 64'(bus.alu_B), word_b);
         chk("busy_exec", 64'(bus.busy), 64'd1);
         chk("in_ready_exec", 64'(bus.in_ready), 64'd0);

         cnt = 0;
         @(negedge clk);
         while (!bus.out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
         end
         chk("out_valid", 64'(bus.out_valid), 64'd1);
         chk("out_data", 64'(bus.out_data), exp_word);
         chk("out_last", 64'(bus.out_last), 64'(i == n - 1));
         if (i == n - 1) chk("flags", 64'(bus.flags), 64'(exp_flags));

         // a stalled source presenting new data must be ignored until IDLE
         for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = ~word_a[W-1:0];
            bus.in_b     = ~word_b[W-1:0];
            @(negedge clk);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_data", 64'(bus.out_data), exp_word);
            chk("stall_op", 64'(bus.alu_opcode), 64'(exp_op));
            chk("stall_A", 64'(bus.alu_A), word_a);
            chk("stall_B", 64'(bus.alu_B), word_b);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
         chk("opcode_ld", 64'(bus.alu_opcode), 64'(OP_LD));
         chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
         chk("busy_after", 64'(bus.busy), 64'(i != n - 1));
         if (i == n - 1) chk("flags_hold", 64'(bus.flags), 64'(exp_flags));
      end
   endtask

   task automatic check_reset_values();
      chk("rst_A", 64'(bus.alu_A), 64'd0);
      chk("rst_B", 64'(bus.alu_B), 64'd0);
      chk("rst_op", 64'(bus.alu_opcode), 64'(OP_LD));
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_last", 64'(bus.out_last), 64'd0);
      chk("rst_flags", 64'(bus.flags), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      int n;
      logic [63:0] ra, rb;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.op_sub    = 1'b0;
      bus.out_ready = 1'b0;
      reset_n       = 1'b0;
      #1;
      check_reset_values();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      run_packet(1, 64'h7F, 64'h01, 1'b0, 0, 1);
      run_packet(2, 64'h01FF, 64'h0001, 1'b0, 0, 2);
      run_packet(4, 64'h0, 64'h1, 1'b1, 0, 4);
      run_packet(2, 64'h0100, 64'h0100, 1'b1, 0, 2);
      run_packet(2, 64'h12F0, 64'h3420, 1'b0, 5, 2);

      // reset after the first word of a carrying 3-word add discards the packet
      run_packet(3, 64'h0000FF, 64'h000001, 1'b0, 0, 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      reset_n = 1'b1;
      run_packet(3, 64'h0000FF, 64'h000001, 1'b0, 0, 3);

      for (int k = 0; k < 40; k++) begin
         n  = int'($urandom_range(1, 4));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         run_packet(n, ra, rb, 1'($urandom_range(1)), int'($urandom_range(0, 2)), n);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_mw_seq.md
Name: alu_mw_seq

Overview:
- Multi-word add/subtract sequencer that acts as the initiator driving the combinational ALU.
- Accepts operand word pairs, least-significant word first, on a valid/ready input stream.
- Issues ADD/ADC or SUB/SBB opcodes to the ALU, choosing between them from the carry/borrow of the previous word.
- Returns result words on a valid/ready output stream, plus packet-level status flags {sign, zero, parity, carry}.
- Sits between the CPU's multi-byte arithmetic micro-sequencer and the ALU.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (8): word width; must match the ALU.
- OP_ADD, default 5'h02: ALU opcode A+B.
- OP_ADC, default 5'h03: ALU opcode A+B+1.
- OP_SBB, default 5'h04: ALU opcode A-B-1.
- OP_SUB, default 5'h05: ALU opcode A-B.
- OP_LD, default 5'h00: ALU opcode driven when idle.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  DATA_WIDTH  operand A word.
- in_b  in  DATA_WIDTH  operand B word.
- in_last  in  1  most-significant (final) word of the packet.
- op_sub  in  1  1=subtract, 0=add; sampled only on the first word of a packet.
- alu_A  out  DATA_WIDTH  registered ALU operand A.
- alu_B  out  DATA_WIDTH  registered ALU operand B.
- alu_opcode  out  5  registered ALU opcode.
- alu_C  in  DATA_WIDTH  ALU result.
- alu_status  in  4  ALU status {sign, zero, parity, carry}.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result word.
- out_data  out  DATA_WIDTH  result word.
- out_last  out  1  final word of the packet.
- flags  out  4  packet status {sign, zero, parity, carry}; valid while out_valid && out_last.
- busy  out  1  a packet is in progress (first word accepted, last word not yet delivered).

Behaviour:
- Async reset (reset_n=0), immediate regardless of state:
  - state=IDLE; alu_A=0, alu_B=0, alu_opcode=OP_LD.
  - out_valid=0, out_data=0, out_last=0, flags=0, busy=0.
  - Internal first=1, carry_r=0, sub_r=0, zacc=1, pacc=0.
- in_ready = (state==IDLE), combinational. It is therefore 1 out of reset.
- IDLE: on in_valid && in_ready:
  - Latch alu_A=in_a, alu_B=in_b, last_r=in_last.
  - If first: sub_r=op_sub; opcode = sub_r ? OP_SUB : OP_ADD.
  - Else: add uses carry_r ? OP_ADC : OP_ADD; subtract uses carry_r ? OP_SBB : OP_SUB.
  - Set busy=1, first=0; go to EXEC.
- EXEC: the ALU settles combinationally during this cycle. At the clock edge:
  - out_data=alu_C, out_last=last_r, out_valid=1, carry_r=alu_status[0].
  - zacc = zacc & alu_status[2]; pacc = pacc ^ alu_status[1].
  - If last_r: flags = {alu_status[3], zacc_next, pacc_next, alu_status[0]}.
  - Go to OUT.
- OUT: out_valid held, and out_data/out_last/alu_* stable, until out_ready.
  - On the handshake: out_valid=0; alu_opcode=OP_LD.
  - If out_last: first=1, zacc=1, pacc=0, carry_r=0, busy=0.
  - Go to IDLE.
- Latency: 3 cycles minimum per word (accept, execute, deliver); throughput is 1 word per 3 cycles with out_ready held high.
- Carry/borrow: the ALU's carry bit is bit DATA_WIDTH of the extended result. For SUB/SBB it equals the borrow (1 when A<B for SUB, A<=B for SBB). The sequencer supplies carry-in only by choosing ADC/SBB; the ALU has no carry input.
- flags[0] is the final carry (add) or final borrow (subtract).
- Packet-level flags:
  - zero = all result words were zero.
  - parity = XOR of all words' even parity.
  - sign = MSB of the last word.
- Single-word packet (in_last on the first word): plain ADD/SUB.
- op_sub changing mid-packet is ignored.
- in_valid while not IDLE is ignored; the source must hold data until in_ready.
- Reset mid-packet: the packet is discarded. The next accepted word is treated as a first word (ADD/SUB, never ADC/SBB).
- flags hold their value until the next packet's last word completes or reset.

Test Plan:
- Single word: add 0x7F+0x01, in_last=1 -> alu_opcode=0x02; out_data=0x80, out_last=1; flags=4'b1010 (sign 1, zero 0, parity 1, carry 0).
- Two-word add 0x01FF+0x0001 -> opcodes 0x02 then 0x03; out words 0x00, 0x02; flags=4'b0010.
- Four-word subtract 0x00000000-0x00000001 -> opcodes 0x05,0x04,0x04,0x04; out 0xFF x4; flags=4'b1001 (sign 1, parity 0, borrow 1).
- Zero result: subtract 0x0100-0x0100 -> opcodes 0x05,0x05; out 0x00,0x00; flags=4'b0100.
- Backpressure: out_ready=0 for 5 cycles during OUT -> out_valid, out_data, alu_opcode and alu_A/alu_B stable; in_ready=0 throughout; the word is accepted on the first out_ready=1 edge.
- Reset mid-packet: reset_n low for 1 cycle after word 1 of a 3-word add that produced a carry -> all outputs at reset values immediately, busy=0; the next packet's first word issues 0x02, not 0x03.
